// File: rtl/demux_wh_pkg.sv
// Shared flit format, type encodings and FSM states for the wormhole demux and
// its control sub-module.
package demux_wh_pkg;

  localparam int DATAW    = 33;
  localparam int DATAW_P1 = DATAW + 1;
  localparam int VCHW     = 0;
  localparam int VCHW_P1  = VCHW + 1;
  localparam int TYPEW    = 2;

  localparam logic ENABLE   = 1'b1;
  localparam logic DISABLE  = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [TYPEW-1:0] {
    TYPE_NONE = 2'b00,
    TYPE_HEAD = 2'b01,
    TYPE_DATA = 2'b10,
    TYPE_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Type field occupies the MSBs of every flit; shared with the mux stages.
  function automatic flit_type_e flit_type(input logic [DATAW_P1-1:0] flit);
    return flit_type_e'(flit[DATAW_P1-1 -: TYPEW]);
  endfunction

endpackage

// File: rtl/demux_wh_ctrl.sv
// Route-lock FSM: decodes flit type, latches the output port on a head and
// releases it on the tail.
module demux_ctrl
  import demux_wh_pkg::*;
(
  input  logic       clk,
  input  logic       rst_,
  input  logic       ivalid,
  input  flit_type_e itype,
  input  logic       route,
  output logic       busy,
  output logic       fwd,
  output logic       fwd_port,
  output logic       tail_done,
  output logic       drop
);

  state_e state_r, state_next_s;
  logic   port_r, port_next_s;

  // State and route register
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_r <= IDLE;
      port_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      port_r  <= port_next_s;
    end
  end

  // Next-state and per-flit decisions; a head picks its port in the same cycle
  always_comb begin
    state_next_s = state_r;
    port_next_s  = port_r;
    fwd          = DISABLE;
    fwd_port     = port_r;
    tail_done    = DISABLE;
    drop         = DISABLE;
    if (ivalid) begin
      case (state_r)
        IDLE: begin
          case (itype)
            TYPE_HEAD: begin
              port_next_s  = route;
              fwd          = ENABLE;
              fwd_port     = route;
              state_next_s = BUSY;
            end
            TYPE_DATA, TYPE_TAIL: drop = ENABLE;
            default:              drop = DISABLE;
          endcase
        end
        BUSY: begin
          case (itype)
            TYPE_DATA: fwd = ENABLE;
            TYPE_TAIL: begin
              fwd          = ENABLE;
              tail_done    = ENABLE;
              state_next_s = IDLE;
            end
            TYPE_HEAD: drop = ENABLE;
            default:   drop = DISABLE;
          endcase
        end
        default: state_next_s = IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  assign busy = (state_r == BUSY);

endmodule

// File: rtl/demux_wh.sv
// Registered 1-to-2 wormhole demultiplexer: holds the route chosen by a head
// flit until its tail passes, with per-port packet counters and a drop counter.
module demux_wh
  import demux_wh_pkg::*;
#(
  parameter int ROUTE_BIT = 0,
  parameter int CNTW      = 16
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [DATAW_P1-1:0] idata,
  input  logic                ivalid,
  input  logic [VCHW_P1-1:0]  ivch,
  output logic [DATAW_P1-1:0] odata_0,
  output logic                ovalid_0,
  output logic [VCHW_P1-1:0]  ovch_0,
  output logic [DATAW_P1-1:0] odata_1,
  output logic                ovalid_1,
  output logic [VCHW_P1-1:0]  ovch_1,
  output logic                busy,
  output logic                err,
  output logic [CNTW-1:0]     pkt_cnt_0,
  output logic [CNTW-1:0]     pkt_cnt_1,
  output logic [CNTW-1:0]     err_cnt
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic fwd_s, fwd_port_s, tail_done_s, drop_s;

  demux_ctrl u_ctrl (
    .clk       (clk),
    .rst_      (rst_),
    .ivalid    (ivalid),
    .itype     (flit_type(idata)),
    .route     (idata[ROUTE_BIT]),
    .busy      (busy),
    .fwd       (fwd_s),
    .fwd_port  (fwd_port_s),
    .tail_done (tail_done_s),
    .drop      (drop_s)
  );

  // Output registers; the idle port is driven to zero so it never toggles
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      odata_0  <= {DATAW_P1{1'b0}};
      ovalid_0 <= 1'b0;
      ovch_0   <= {VCHW_P1{1'b0}};
      odata_1  <= {DATAW_P1{1'b0}};
      ovalid_1 <= 1'b0;
      ovch_1   <= {VCHW_P1{1'b0}};
      err      <= 1'b0;
    end else begin
      if (fwd_s && !fwd_port_s) begin
        odata_0  <= idata;
        ovalid_0 <= 1'b1;
        ovch_0   <= ivch;
      end else begin
        odata_0  <= {DATAW_P1{1'b0}};
        ovalid_0 <= 1'b0;
        ovch_0   <= {VCHW_P1{1'b0}};
      end
      if (fwd_s && fwd_port_s) begin
        odata_1  <= idata;
        ovalid_1 <= 1'b1;
        ovch_1   <= ivch;
      end else begin
        odata_1  <= {DATAW_P1{1'b0}};
        ovalid_1 <= 1'b0;
        ovch_1   <= {VCHW_P1{1'b0}};
      end
      err <= drop_s;
    end
  end

  // Packet counters wrap; the drop counter saturates
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pkt_cnt_0 <= {CNTW{1'b0}};
      pkt_cnt_1 <= {CNTW{1'b0}};
      err_cnt   <= {CNTW{1'b0}};
    end else begin
      if (tail_done_s && !fwd_port_s) begin
        pkt_cnt_0 <= pkt_cnt_0 + CNT_ONE;
      end else begin
        pkt_cnt_0 <= pkt_cnt_0;
      end
      if (tail_done_s && fwd_port_s) begin
        pkt_cnt_1 <= pkt_cnt_1 + CNT_ONE;
      end else begin
        pkt_cnt_1 <= pkt_cnt_1;
      end
      if (drop_s && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + CNT_ONE;
      end else begin
        err_cnt <= err_cnt;
      end
    end
  end

endmodule

// File: tb/tb_demux_wh.sv
// Randomized scoreboard bench for demux_wh: a packet-level model predicts
// per-cycle port activity and flit contents; a monitor compares each cycle.
module tb_demux_wh;
  import demux_wh_pkg::*;

  localparam int CNTW = 5;
  localparam int RB   = 0;
  localparam int CMAX = (1 << CNTW) - 1;

  logic                clk = 1'b0;
  logic                rst_;
  logic [DATAW_P1-1:0] idata;
  logic                ivalid;
  logic [VCHW_P1-1:0]  ivch;
  logic [DATAW_P1-1:0] odata_0, odata_1;
  logic                ovalid_0, ovalid_1;
  logic [VCHW_P1-1:0]  ovch_0, ovch_1;
  logic                busy, err;
  logic [CNTW-1:0]     pkt_cnt_0, pkt_cnt_1, err_cnt;

  demux_wh #(.ROUTE_BIT(RB), .CNTW(CNTW)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .odata_0(odata_0), .ovalid_0(ovalid_0), .ovch_0(ovch_0),
    .odata_1(odata_1), .ovalid_1(ovalid_1), .ovch_1(ovch_1),
    .busy(busy), .err(err), .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy;
    logic err;
    logic v0;
    logic v1;
  } cyc_t;

  cyc_t                             cyc_q[$];
  logic [DATAW_P1+VCHW_P1-1:0]      p0_q[$];
  logic [DATAW_P1+VCHW_P1-1:0]      p1_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state: are we inside a packet, and which port owns it
  bit in_pkt = 1'b0;
  bit lock   = 1'b0;
  int m_pkt0 = 0, m_pkt1 = 0, m_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic v, input flit_type_e t, input logic [DATAW_P1-1:0] f,
                       input logic [VCHW_P1-1:0] vc);
    cyc_t c;
    bit   fwd;
    c   = '0;
    fwd = 1'b0;
    if (v && t != TYPE_NONE) begin
      if (!in_pkt) begin
        if (t == TYPE_HEAD) begin
          lock   = f[RB];
          in_pkt = 1'b1;
          fwd    = 1'b1;
        end else begin
          c.err = 1'b1;
        end
      end else if (t == TYPE_HEAD) begin
        c.err = 1'b1;
      end else begin
        fwd = 1'b1;
        if (t == TYPE_TAIL) begin
          in_pkt = 1'b0;
          if (lock) m_pkt1 = (m_pkt1 + 1) % (CMAX + 1);
          else      m_pkt0 = (m_pkt0 + 1) % (CMAX + 1);
        end
      end
    end
    if (c.err && m_err < CMAX) m_err++;
    if (fwd) begin
      if (lock) begin c.v1 = 1'b1; p1_q.push_back({f, vc}); end
      else      begin c.v0 = 1'b1; p0_q.push_back({f, vc}); end
    end
    c.busy = in_pkt;
    cyc_q.push_back(c);
  endtask

  task automatic send(input logic v, input flit_type_e t, input logic [31:0] pl);
    logic [VCHW_P1-1:0] vc;
    vc = VCHW_P1'($urandom);
    @(negedge clk);
    ivalid = v;
    idata  = {t, pl};
    ivch   = vc;
    @(posedge clk);
    model(v, t, {t, pl}, vc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, TYPE_NONE, 32'h0);
  endtask

  task automatic packet(input logic [31:0] dest, input int ndata);
    send(1'b1, TYPE_HEAD, dest);
    for (int i = 0; i < ndata; i++) send(1'b1, TYPE_DATA, $urandom);
    send(1'b1, TYPE_TAIL, $urandom);
  endtask

  task automatic checkpoint(input string name);
    idle(1);
    @(negedge clk);
    #1;
    check({name, "_pkt_cnt_0"}, 64'(pkt_cnt_0), 64'(m_pkt0));
    check({name, "_pkt_cnt_1"}, 64'(pkt_cnt_1), 64'(m_pkt1));
    check({name, "_err_cnt"},   64'(err_cnt),   64'(m_err));
    check({name, "_p0_pending"}, 64'(p0_q.size()), 64'd0);
    check({name, "_p1_pending"}, 64'(p1_q.size()), 64'd0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_port0"}, {odata_0, ovalid_0, ovch_0}, 64'd0);
    check({name, "_port1"}, {odata_1, ovalid_1, ovch_1}, 64'd0);
    check({name, "_status"}, {busy, err, pkt_cnt_0, pkt_cnt_1, err_cnt}, 64'd0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    ivalid = 1'b0;
    #2 rst_ = 1'b0;
    #1 check_zero(name);
    in_pkt = 1'b0;
    lock   = 1'b0;
    m_pkt0 = 0;
    m_pkt1 = 0;
    m_err  = 0;
    cyc_q.delete();
    p0_q.delete();
    p1_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  // Monitor: compares each post-edge cycle against the model's expectation
  always @(negedge clk) begin
    cyc_t                        c;
    logic [DATAW_P1+VCHW_P1-1:0] e;
    if (rst_ === 1'b1) begin
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        check("busy",     64'(busy),     64'(c.busy));
        check("err",      64'(err),      64'(c.err));
        check("ovalid_0", 64'(ovalid_0), 64'(c.v0));
        check("ovalid_1", 64'(ovalid_1), 64'(c.v1));
      end else begin
        check("spurious_valid", {ovalid_0, ovalid_1}, 64'd0);
      end
      if (ovalid_0) begin
        if (p0_q.size() == 0) check("p0_extra_flit", 64'd0, 64'd1);
        else begin
          e = p0_q.pop_front();
          check("p0_flit", {odata_0, ovch_0}, 64'(e));
        end
      end else begin
        check("p0_idle_zero", {odata_0, ovch_0}, 64'd0);
      end
      if (ovalid_1) begin
        if (p1_q.size() == 0) check("p1_extra_flit", 64'd0, 64'd1);
        else begin
          e = p1_q.pop_front();
          check("p1_flit", {odata_1, ovch_1}, 64'(e));
        end
      end else begin
        check("p1_idle_zero", {odata_1, ovch_1}, 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] pat [4];
    flit_type_e  rt;
    pat[0] = 18'h3FFFF; pat[1] = 18'h2AAAA; pat[2] = 18'h15555; pat[3] = 18'h00001;
    rst_   = 1'b0;
    ivalid = 1'b0;
    idata  = '0;
    ivch   = '0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset_state");
    @(negedge clk);
    rst_ = 1'b1;

    // Destination 0x09 routes to port 1
    packet(32'h09, 20);
    checkpoint("long_pkt_port1");

    do_reset("rst2");
    for (int p = 0; p < 10; p++) begin
      send(1'b1, TYPE_HEAD, 32'h04);
      for (int k = 0; k < 4; k++) send(1'b1, TYPE_DATA, {14'h0, pat[k]});
      send(1'b1, TYPE_TAIL, {14'h0, pat[p % 4]});
      idle(7);
    end
    checkpoint("ten_pkts_port0");

    // Tail then head with no gap, switching ports
    packet(32'h09, 2);
    packet(32'h04, 2);
    packet(32'h09, 0);
    checkpoint("back_to_back");

    // Data in IDLE and a head inside a packet are both dropped
    send(1'b1, TYPE_DATA, 32'h1234);
    send(1'b1, TYPE_HEAD, 32'h05);
    send(1'b1, TYPE_DATA, $urandom);
    send(1'b1, TYPE_HEAD, 32'h04);
    send(1'b1, TYPE_DATA, $urandom);
    send(1'b1, TYPE_TAIL, $urandom);
    checkpoint("drops");

    do_reset("rst_pre_mid");
    send(1'b1, TYPE_HEAD, 32'h04);
    for (int i = 0; i < 5; i++) send(1'b1, TYPE_DATA, $urandom);
    do_reset("rst_mid_pkt");
    for (int i = 0; i < 15; i++) send(1'b1, TYPE_DATA, $urandom);
    send(1'b1, TYPE_TAIL, $urandom);
    checkpoint("abandoned_pkt");

    do_reset("rst_sat");
    for (int i = 0; i < CMAX + 9; i++) send(1'b1, (i % 2 == 0) ? TYPE_DATA : TYPE_TAIL, $urandom);
    checkpoint("err_saturate");

    do_reset("rst_wrap");
    for (int i = 0; i < CMAX + 2; i++) packet(32'h04, i % 2);
    checkpoint("pkt_wrap");

    for (int i = 0; i < 400; i++) begin
      rt = flit_type_e'($urandom_range(3, 0));
      send(1'($urandom_range(1, 0)), rt, $urandom);
    end
    checkpoint("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
